// File: rtl/pipe_defs.sv
// pipe_defs: shared PC constants, exception cause codes, redirect FSM states and request priorities.
package pipe_defs;
    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
    localparam logic [PC_W-1:0] EXC_BASE = 16'hFF00;
    localparam int VEC_SHIFT = 2;
    localparam logic [2:0] CAUSE_RESET    = 3'd0;
    localparam logic [2:0] CAUSE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CAUSE_MISALIGN = 3'd2;
    localparam logic [2:0] CAUSE_SYSCALL  = 3'd3;
    localparam logic [2:0] CAUSE_BREAK    = 3'd4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } state_t;
    typedef logic [1:0] prio_t;
    localparam prio_t PRIO_NONE = 2'd0;
    localparam prio_t PRIO_JMP  = 2'd1;
    localparam prio_t PRIO_BR   = 2'd2;
    localparam prio_t PRIO_EXC  = 2'd3;
endpackage

// File: rtl/redirect_arb.sv
// redirect_arb: priority select among exception, taken branch and jump, with exception vector computation.
module redirect_arb #(
    parameter int PC_W = pipe_defs::PC_W,
    parameter logic [PC_W-1:0] EXC_BASE = pipe_defs::EXC_BASE,
    parameter int VEC_SHIFT = pipe_defs::VEC_SHIFT
) (
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            exc_valid,
    input  logic [2:0]      exc_cause,
    output logic            req,
    output logic [PC_W-1:0] target,
    output logic            is_exc,
    output logic [1:0]      prio
);
    import pipe_defs::*;
    logic            br_req;
    logic [PC_W-1:0] vec;
    always_comb begin
        br_req = br_valid & br_taken;
        vec    = EXC_BASE + (PC_W'(exc_cause) << VEC_SHIFT);
        is_exc = exc_valid;
        req    = exc_valid | br_req | jmp_valid;
        target = exc_valid ? vec : br_req ? br_target : jmp_target;
        prio   = exc_valid ? PRIO_EXC : br_req ? PRIO_BR : jmp_valid ? PRIO_JMP : PRIO_NONE;
    end
endmodule

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: arbitrates redirect requests, holds a PC load until IF accepts it, then flushes wrong-path stages.
module redirect_ctrl #(
    parameter int PC_W = pipe_defs::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = pipe_defs::RESET_PC,
    parameter logic [PC_W-1:0] EXC_BASE = pipe_defs::EXC_BASE,
    parameter int VEC_SHIFT = pipe_defs::VEC_SHIFT,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            exc_valid,
    input  logic [2:0]      exc_cause,
    input  logic [PC_W-1:0] exc_pc,
    input  logic            if_ready,
    output logic            load_pc,
    output logic [PC_W-1:0] pc_in,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic [PC_W-1:0] epc,
    output logic            busy,
    output logic [15:0]     redirect_cnt
);
    import pipe_defs::*;
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [1:0]      prio_q;
    logic            req, is_exc, take, accept;
    logic [PC_W-1:0] target;
    logic [1:0]      prio;
    redirect_arb #(.PC_W(PC_W), .EXC_BASE(EXC_BASE), .VEC_SHIFT(VEC_SHIFT)) u_arb (
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp_valid (jmp_valid),
        .jmp_target(jmp_target),
        .exc_valid (exc_valid),
        .exc_cause (exc_cause),
        .req       (req),
        .target    (target),
        .is_exc    (is_exc),
        .prio      (prio)
    );
    // take: latch a new winner; in ISSUE an override beats acceptance on the same edge
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        take    = (state == IDLE && req) || (state == ISSUE && req && prio > prio_q) ||
                  (state == FLUSH && is_exc);
        accept  = state == ISSUE && !take && if_ready;
        if (take)
            state_d = ISSUE;
        else if (accept) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
        end else if (state == FLUSH) begin
            state_d = (cnt == '0) ? IDLE : FLUSH;
            cnt_d   = (cnt == '0) ? cnt : cnt - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            prio_q       <= PRIO_NONE;
            pc_in        <= RESET_PC;
            epc          <= '0;
            load_pc      <= 1'b0;
            flush_if_id  <= 1'b0;
            flush_id_ex  <= 1'b0;
            busy         <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            prio_q       <= take ? prio : prio_q;
            pc_in        <= take ? target : pc_in;
            epc          <= (take && is_exc) ? exc_pc : epc;
            load_pc      <= state_d == ISSUE;
            flush_if_id  <= state_d != IDLE;
            flush_id_ex  <= state_d == FLUSH;
            busy         <= state_d != IDLE;
            redirect_cnt <= (accept && redirect_cnt != 16'hFFFF) ? redirect_cnt + 16'd1 : redirect_cnt;
        end
    end
endmodule

// File: tb/tb_redirect_ctrl.sv
// tb_redirect_ctrl: directed and random stimulus against a transaction-level reference model of the redirect controller.
module tb_redirect_ctrl;
    localparam int FLUSH_CYCLES = 2;
    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid, br_taken, jmp_valid, exc_valid, if_ready;
    logic [15:0] br_target, jmp_target, exc_pc;
    logic [2:0]  exc_cause;
    logic        load_pc, flush_if_id, flush_id_ex, busy;
    logic [15:0] pc_in, epc, redirect_cnt;
    int          vecs = 0;
    int          errs = 0;
    bit          run = 0;

    redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .if_ready(if_ready),
        .load_pc(load_pc), .pc_in(pc_in), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .epc(epc), .busy(busy), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pending;
        int          lvl;
        int          flush_left;
        logic [15:0] pc;
        logic [15:0] epc;
        int          count;
    } model_t;
    model_t m;

    function automatic model_t next_model(model_t s);
        int          lvl;
        logic [15:0] tgt;
        bit          idle;
        lvl  = exc_valid ? 3 : (br_valid && br_taken) ? 2 : jmp_valid ? 1 : 0;
        tgt  = exc_valid ? 16'(32'hFF00 + 32'(exc_cause) * 4) :
               (br_valid && br_taken) ? br_target : jmp_target;
        idle = !s.pending && s.flush_left == 0;
        if ((s.pending && lvl > s.lvl) || (!s.pending && s.flush_left > 0 && exc_valid) ||
            (idle && lvl > 0)) begin
            s.pending    = 1;
            s.lvl        = lvl;
            s.pc         = tgt;
            s.flush_left = 0;
            if (exc_valid) s.epc = exc_pc;
        end else if (s.pending && if_ready) begin
            s.pending    = 0;
            s.flush_left = FLUSH_CYCLES;
            if (s.count < 65535) s.count = s.count + 1;
        end else if (s.flush_left > 0)
            s.flush_left = s.flush_left - 1;
        return s;
    endfunction

    always @(posedge clk or negedge rst)
        if (!rst) m <= '{0, 0, 0, 16'h0000, 16'h0000, 0};
        else m <= next_model(m);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("m_load_pc", 32'(load_pc), 32'(m.pending));
        chk("m_pc_in", 32'(pc_in), 32'(m.pc));
        chk("m_flush_if_id", 32'(flush_if_id), 32'(m.pending || m.flush_left > 0));
        chk("m_flush_id_ex", 32'(flush_id_ex), 32'(!m.pending && m.flush_left > 0));
        chk("m_busy", 32'(busy), 32'(m.pending || m.flush_left > 0));
        chk("m_epc", 32'(epc), 32'(m.epc));
        chk("m_redirect_cnt", 32'(redirect_cnt), 32'(m.count));
    end

    task automatic clear_req();
        br_valid = 0; br_taken = 0; jmp_valid = 0; exc_valid = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 0;
        clear_req();
        br_target = 0; jmp_target = 0; exc_pc = 0; exc_cause = 0; if_ready = 1;
        cyc(3);
        run = 1;
        rst = 1;
        chk("reset_pc_in", 32'(pc_in), 32'h0000);
        chk("reset_load_pc", 32'(load_pc), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cnt", 32'(redirect_cnt), 0);
        cyc(1);
        br_valid = 1; br_taken = 1; br_target = 16'hFF33;
        cyc(1);
        chk("br_load_pc", 32'(load_pc), 1);
        chk("br_pc_in", 32'(pc_in), 32'hFF33);
        clear_req();
        cyc(1);
        chk("br_load_drop", 32'(load_pc), 0);
        chk("br_flush1", 32'(flush_id_ex), 1);
        cyc(1);
        chk("br_flush2", 32'(flush_id_ex), 1);
        cyc(1);
        chk("br_idle_flush", 32'(flush_id_ex), 0);
        chk("br_idle_busy", 32'(busy), 0);
        chk("br_cnt", 32'(redirect_cnt), 1);
        br_valid = 1; br_taken = 0; br_target = 16'h5555;
        cyc(1);
        chk("nt_load_pc", 32'(load_pc), 0);
        chk("nt_busy", 32'(busy), 0);
        clear_req();
        if_ready = 0; jmp_valid = 1; jmp_target = 16'h0040;
        cyc(1);
        chk("bp_load_pc", 32'(load_pc), 1);
        chk("bp_pc_in", 32'(pc_in), 32'h0040);
        clear_req();
        cyc(1);
        chk("bp_hold_pc", 32'(pc_in), 32'h0040);
        exc_valid = 1; exc_cause = 3'd3; exc_pc = 16'h1234;
        cyc(1);
        chk("ovr_pc_in", 32'(pc_in), 32'hFF0C);
        chk("ovr_epc", 32'(epc), 32'h1234);
        chk("ovr_load_pc", 32'(load_pc), 1);
        clear_req();
        if_ready = 1;
        cyc(1);
        chk("ovr_accept_load", 32'(load_pc), 0);
        chk("ovr_cnt", 32'(redirect_cnt), 2);
        cyc(3);
        exc_valid = 1; exc_cause = 3'd1; exc_pc = 16'h0777;
        br_valid = 1; br_taken = 1; br_target = 16'h0100;
        cyc(1);
        chk("sim_pc_in", 32'(pc_in), 32'hFF04);
        clear_req();
        cyc(4);
        chk("sim_pc_hold", 32'(pc_in), 32'hFF04);
        chk("sim_cnt", 32'(redirect_cnt), 3);
        jmp_valid = 1; jmp_target = 16'h0300;
        cyc(1);
        clear_req();
        cyc(1);
        chk("ar_in_flush", 32'(flush_id_ex), 1);
        #2 rst = 0;
        #1;
        chk("ar_load_pc", 32'(load_pc), 0);
        chk("ar_pc_in", 32'(pc_in), 32'h0000);
        chk("ar_flush_if_id", 32'(flush_if_id), 0);
        chk("ar_flush_id_ex", 32'(flush_id_ex), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_epc", 32'(epc), 0);
        chk("ar_cnt", 32'(redirect_cnt), 0);
        cyc(1);
        rst = 1;
        jmp_valid = 1; jmp_target = 16'h0200;
        cyc(1);
        chk("post_load_pc", 32'(load_pc), 1);
        chk("post_pc_in", 32'(pc_in), 32'h0200);
        clear_req();
        cyc(4);
        repeat (4000) begin
            @(negedge clk);
            exc_valid  = ($urandom % 12) == 0;
            exc_cause  = 3'($urandom);
            exc_pc     = 16'($urandom);
            br_valid   = ($urandom % 4) == 0;
            br_taken   = $urandom % 2;
            br_target  = 16'($urandom);
            jmp_valid  = ($urandom % 5) == 0;
            jmp_target = 16'($urandom);
            if_ready   = ($urandom % 3) != 0;
            if (($urandom % 400) == 0) begin
                #2 rst = 0;
                @(negedge clk);
                rst = 1;
            end
        end
        @(negedge clk);
        run = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Drives the IF stage's PC-load interface (load_pc, pc_in) from the execute side of the pipeline.
- Collects redirect requests from three sources: EX branch resolution, ID jumps and exceptions.
- Arbitrates by priority and issues a held load_pc request until IF accepts it.
- Then flushes the wrong-path instructions in IF/ID and ID/EX for a fixed number of cycles.

Parameters:
- PC_W, 16, width of every PC/target bus.
- RESET_PC, 16'h0000, value driven on pc_in during and after reset.
- EXC_BASE, 16'hFF00, exception vector table base.
- VEC_SHIFT, 2, log2 of the vector stride (vector = EXC_BASE + (cause << VEC_SHIFT)).
- FLUSH_CYCLES, 2, cycles the flush outputs stay high after the load is accepted (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- br_valid  in  1  EX has resolved a conditional branch this cycle.
- br_taken  in  1  resolved branch is taken; ignored when br_valid=0.
- br_target  in  PC_W  taken-branch target.
- jmp_valid  in  1  ID decoded an unconditional jump.
- jmp_target  in  PC_W  jump target.
- exc_valid  in  1  exception raised this cycle.
- exc_cause  in  3  exception cause code.
- exc_pc  in  PC_W  PC of the faulting instruction.
- if_ready  in  1  IF can accept a PC load this cycle.
- load_pc  out  1  PC load request to IF.
- pc_in  out  PC_W  PC value to load.
- flush_if_id  out  1  kill the IF/ID pipeline register.
- flush_id_ex  out  1  kill the ID/EX pipeline register.
- epc  out  PC_W  saved exc_pc of the last accepted exception.
- busy  out  1  state != IDLE.
- redirect_cnt  out  16  saturating count of accepted loads.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, load_pc=0, pc_in=RESET_PC, both flushes=0, epc=0, redirect_cnt=0, busy=0.
- Reset mid-operation aborts any pending or flushing redirect; no load_pc glitch on deassertion.
- All outputs are registered.
- States: IDLE, ISSUE, FLUSH.
- Priority: exc_valid > (br_valid & br_taken) > jmp_valid.
- Effective request: br_valid & !br_taken is not a request.
- IDLE:
  - On a clock edge with an effective request, register the winner's target into pc_in and go to ISSUE. load_pc=1 from the next cycle, so latency is 1 cycle.
  - Target by source:
    - exc: EXC_BASE + ({13'b0,exc_cause} << VEC_SHIFT), truncated mod 2^PC_W.
    - br: br_target.
    - jmp: jmp_target.
  - An exception winner also registers epc <= exc_pc in the same edge.
  - Losing requests in the same cycle are discarded; they come from wrong-path instructions.
- ISSUE:
  - load_pc=1 and flush_if_id=1 every cycle.
  - pc_in is held stable while if_ready=0.
  - Handshake: load is accepted on the edge where load_pc=1 and if_ready=1. Next state is FLUSH with counter=FLUSH_CYCLES-1, load_pc drops to 0, and redirect_cnt increments (saturates at 16'hFFFF).
  - A new request that strictly outranks the pending one replaces pc_in (and epc if exc) on that edge and stays in ISSUE. Equal or lower requests are ignored.
  - A replacement on the acceptance edge wins: stay in ISSUE with the new target, and do not count the old one.
- FLUSH:
  - flush_if_id=1 and flush_id_ex=1; load_pc=0.
  - Counter decrements each cycle; at 0, next state is IDLE.
  - Branch and jump requests are ignored (wrong path).
  - exc_valid preempts: go to ISSUE with the vector target and update epc.
- IDLE outputs: load_pc=0, both flushes=0; pc_in holds its last value.
- Simultaneous exc and taken branch: the exception wins; the branch is dropped.

Decomposition:
- Shared package/header `pipe_defs`:
  - PC_W, RESET_PC, EXC_BASE, VEC_SHIFT.
  - Exception cause encodings.
  - State encoding localparams IDLE=2'd0, ISSUE=2'd1, FLUSH=2'd2.
- One natural sub-module: `redirect_arb`, purely combinational. It holds the priority select and vector computation, and outputs req, target, is_exc and a priority level for the override compare.

Test Plan:
- Reset then idle: rst low 3 cycles, release -> pc_in=16'h0000, load_pc=0, busy=0, redirect_cnt=0.
- Taken branch, if_ready=1: br_valid=1, br_taken=1, br_target=16'hFF33 for one cycle -> next cycle load_pc=1, pc_in=16'hFF33 for exactly 1 cycle. Then flush_if_id and flush_id_ex high 2 cycles, then IDLE. redirect_cnt=1.
- Not-taken branch: br_valid=1, br_taken=0 -> no load_pc, busy stays 0.
- Backpressure plus override:
  - jmp_target=16'h0040 with if_ready=0 -> load_pc held with pc_in=16'h0040.
  - Exception with cause=3, exc_pc=16'h1234 while held -> pc_in=16'hFF0C, epc=16'h1234.
  - Then if_ready=1 -> single acceptance, redirect_cnt increments once.
- Simultaneous exc (cause=1) and taken branch (16'h0100) -> pc_in=16'hFF04; the branch never appears on pc_in.
- Asynchronous reset asserted mid-FLUSH, off-edge -> all outputs return to reset values immediately; after release a new jmp to 16'h0200 issues normally.
